// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3/state types and legality helper for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_funct3_e;

    // Stores share the size encoding of the signed loads.
    localparam lsu_funct3_e SB = LB;
    localparam lsu_funct3_e SH = LH;
    localparam lsu_funct3_e SW = LW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // True when funct3 names an access this unit can perform.
    function automatic logic funct3_legal(input logic is_write, input logic [2:0] f3);
        if (is_write) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication/strobes, load extraction and alignment check
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] load_ext_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store formatting and alignment depend only on the access size in funct3[1:0].
    always_comb begin
        bus_wdata  = wdata;
        bus_wstrb  = 4'b1111;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                bus_wdata = {4{wdata[7:0]}};
                bus_wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                bus_wdata  = {2{wdata[15:0]}};
                bus_wstrb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

    // Pick the addressed byte/halfword and extend it according to signedness.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      load_ext_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_ext_data = {{16{half_sel[15]}}, half_sel};
            LW:      load_ext_data = rdata;
            LBU:     load_ext_data = {24'd0, byte_sel};
            LHU:     load_ext_data = {16'd0, half_sel};
            default: load_ext_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit on a valid/ready bus (optional LSU_TIMEOUT_EN)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    lsu_state_e  state;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic        lat_write;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;
    logic [31:0] load_ext;
    logic        misaligned;
    logic        req_bad;
    logic        timeout_hit;

    assign req_ready = (state == ST_IDLE);

    // The aligner sees the live request while idle and the latched one afterwards.
    assign sel_funct3  = (state == ST_IDLE) ? req_funct3    : lat_funct3;
    assign sel_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : lat_addr_lo;
    assign req_bad     = misaligned || !funct3_legal(req_write, req_funct3);

    lsu_lane_align u_lane_align (
        .funct3        (sel_funct3),
        .addr_lo       (sel_addr_lo),
        .wdata         (req_wdata),
        .rdata         (bus_rdata),
        .bus_wdata     (fmt_wdata),
        .bus_wstrb     (fmt_wstrb),
        .load_ext_data (load_ext),
        .misaligned    (misaligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count bus wait cycles; held at zero outside BUS so every transaction starts fresh.
    always_ff @(posedge clk) begin
        if (reset || state != ST_BUS) begin
            wait_cnt <= '0;
        end else if (!bus_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = !bus_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Transaction FSM: accept and check, drive the bus, then pulse the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_funct3  <= 3'd0;
            lat_addr_lo <= 2'd0;
            lat_write   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_error   <= 1'b0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_wstrb   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_funct3  <= req_funct3;
                        lat_addr_lo <= req_addr[1:0];
                        lat_write   <= req_write;
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= ST_RESP;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_we    <= req_write;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_wdata <= req_write ? fmt_wdata : 32'd0;
                            bus_wstrb <= req_write ? fmt_wstrb : 4'd0;
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ready || timeout_hit) begin
                        bus_valid <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_wdata <= 32'd0;
                        bus_wstrb <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_error <= !bus_ready || bus_err;
                        rsp_rdata <= (!bus_ready || bus_err || lat_write) ? 32'd0 : load_ext;
                        state     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= 32'd0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic wr, input logic [2:0] f3);
        if (wr) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Issue one request, play the bus with wait_n stall cycles, and check every cycle.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_n, input logic [31:0] rd,
                          input logic err);
        logic        bad;
        logic        tmo;
        int          sz;
        int          lo;
        int          eff;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        sz  = m_size(f3);
        lo  = int'(addr[1:0]);
        bad = !m_legal(wr, f3) || ((lo % sz) != 0);
        for (int k = 0; k < 4; k++) begin
            e_strb[k]         = (k >= lo) && (k < lo + sz);
            e_wdata[8*k +: 8] = wd[8*(k % sz) +: 8];
        end
        e_rdata = rd >> (8 * lo);
        if (sz == 1) e_rdata = (!f3[2] && e_rdata[7])  ? (e_rdata | 32'hFFFF_FF00) : (e_rdata & 32'hFF);
        if (sz == 2) e_rdata = (!f3[2] && e_rdata[15]) ? (e_rdata | 32'hFFFF_0000) : (e_rdata & 32'hFFFF);

        chk("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        bus_ready = 1'b0; bus_rdata = rd; bus_err = err;
        step();
        // Keep presenting junk: it must not be consumed while busy.
        req_write = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (bad) begin
            chk("err_rsp_valid", rsp_valid, 1);
            chk("err_rsp_error", rsp_error, 1);
            chk("err_rsp_rdata", rsp_rdata, 0);
            chk("err_no_bus",    bus_valid, 0);
            chk("err_req_ready", req_ready, 0);
        end else begin
            tmo = 1'b0;
            eff = wait_n;
`ifdef LSU_TIMEOUT_EN
            if (wait_n >= TMO) begin
                tmo = 1'b1;
                eff = TMO;
            end
`endif
            for (int i = 0; i < eff + (tmo ? 0 : 1); i++) begin
                if (!tmo && i == eff) bus_ready = 1'b1;
                chk("bus_valid", bus_valid, 1);
                chk("bus_we",    bus_we, wr);
                chk("bus_addr",  bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_wstrb", bus_wstrb, wr ? e_strb : 4'd0);
                if (wr) chk("bus_wdata", bus_wdata, e_wdata);
                chk("busy_req_ready", req_ready, 0);
                chk("busy_no_rsp",    rsp_valid, 0);
                step();
            end
            bus_ready = 1'b0;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_error", rsp_error, tmo | err);
            chk("rsp_rdata", rsp_rdata, (tmo | err | wr) ? 32'd0 : e_rdata);
            chk("bus_dropped", bus_valid, 0);
        end
        step();
        req_valid = 1'b0;
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
        step();
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_we",    bus_we, 0);
        chk("rst_bus_addr",  bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        reset = 1'b0;
        step();
        chk("rst_req_ready", req_ready, 1);

        do_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        do_req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 32'h0, 1'b0);
        do_req(1'b0, 3'b000, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 1'b0);
        do_req(1'b0, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 1'b0);
        do_req(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 1'b0);
        do_req(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 1'b0);
        do_req(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0, 1'b0);
        do_req(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0);
        do_req(1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 0, 32'h0, 1'b0);
        do_req(1'b1, 3'b001, 32'h0000_0106, 32'h0000_CAFE, 5, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5, 32'h1357_9BDF, 1'b1);
        do_req(1'b0, 3'b010, 32'h0000_0204, 32'h0, 6, 32'h2468_ACE0, 1'b0);

        // Reset in the middle of a stalled bus transaction.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
        bus_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("mid_bus_valid", bus_valid, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_bus_valid", bus_valid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        bus_ready = 1'b1;
        step();
        chk("abort_no_rsp", rsp_valid, 0);
        chk("abort_no_bus", bus_valid, 0);
        bus_ready = 1'b0;

        for (int t = 0; t < 60; t++) begin
            int w;
            w = (t % 8 == 7) ? 6 : int'($urandom_range(0, 3));
            do_req(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, w, $urandom,
                   ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
